// File: rtl/app_stream_pkg.sv
// Shared types for the application injection stream receiver: field tags,
// parser states (same encodings as the field tags) and the mapping-tag value.
package app_stream_pkg;

    // Field tag attached to every buffered flit.
    typedef enum logic [3:0] {
        F_DSIZE = 4'd0,
        F_TCNT  = 4'd1,
        F_MAP   = 4'd2,
        F_TAG   = 4'd3,
        F_GRAPH = 4'd4,
        F_TEXT  = 4'd5,
        F_DATA  = 4'd6,
        F_BSS   = 4'd7,
        F_ENTRY = 4'd8,
        F_BIN   = 4'd9
    } app_field_e;

    // Parser state; each state tags the flit it consumes with the field of
    // the same encoding, so a state converts to its field with a plain cast.
    typedef enum logic [3:0] {
        S_DSIZE = 4'd0,
        S_TCNT  = 4'd1,
        S_MAP   = 4'd2,
        S_TAG   = 4'd3,
        S_GRAPH = 4'd4,
        S_TEXT  = 4'd5,
        S_DATA  = 4'd6,
        S_BSS   = 4'd7,
        S_ENTRY = 4'd8,
        S_BIN   = 4'd9
    } parser_state_e;

    // Value every tag flit must carry.
    localparam int TASK_TAG = 1;

    // Fields that belong to a specific task carry its index.
    function automatic logic field_has_task(input app_field_e f);
        return f inside {F_MAP, F_TAG, F_TEXT, F_DATA, F_BSS, F_ENTRY, F_BIN};
    endfunction

endpackage

// File: rtl/app_flit_fifo.sv
// Small synchronous FIFO with a registered head: the entry written on one
// edge is visible on data_o after that edge, and data_o keeps its last value
// while the FIFO is empty.
module app_flit_fifo
#(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [WIDTH-1:0]       data_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] head_q;
    logic             do_push;
    logic             do_pop;

    // Overflow/underflow requests are ignored so pointers never corrupt.
    assign do_push = push_i && (count_q < CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign count_o = count_q;
    assign data_o  = head_q;

    // Next read pointer and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            // The new head is either the slot being written right now or an
            // older slot already in the array; when empty, hold the last head.
            if (count_d != '0) begin
                if (do_push && (rd_ptr_d == wr_ptr_q)) begin
                    head_q <= push_data_i;
                end else begin
                    head_q <= mem_q[rd_ptr_d];
                end
            end
        end
    end

endmodule

// File: rtl/app_stream_receiver.sv
// Receiving end of the application injection stream. Parses each record
// (descriptor size, task count, map/tag pairs, graph words, per-task
// text/data/bss/entry headers and binary words), tags every accepted flit
// with its field and task index and buffers it for the injector.
//
// Handshakes:
//   input  side: a flit transfers on a rising clk_i edge when tx_i && credit_o;
//                credit_o depends only on registered state, never on tx_i or
//                on a same-cycle pop.
//   output side: a buffered flit transfers when out_valid_o && out_ready_i;
//                out_* stay stable while out_valid_o is high and not taken.
module app_stream_receiver
    import app_stream_pkg::*;
#(
    parameter int FLIT_SIZE  = 32,
    parameter int BUF_DEPTH  = 4,
    parameter int TASK_IDX_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tx_i,
    input  logic [FLIT_SIZE-1:0]  data_i,
    output logic                  credit_o,
    input  logic                  eoa_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [3:0]            out_field_o,
    output logic [TASK_IDX_W-1:0] out_task_o,
    output logic [FLIT_SIZE-1:0]  out_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int ENTRY_W = FLIT_SIZE + 4 + TASK_IDX_W;
    localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
    // Largest task count the task index can represent without wrapping.
    localparam logic [FLIT_SIZE:0] TASK_LIMIT = {{FLIT_SIZE{1'b0}}, 1'b1} << TASK_IDX_W;

    parser_state_e state_q, state_d;

    logic [FLIT_SIZE-1:0] dsize_q, dsize_d;
    logic [FLIT_SIZE-1:0] tcnt_q, tcnt_d;
    logic [FLIT_SIZE-1:0] task_q, task_d;
    logic [FLIT_SIZE-1:0] gcnt_q, gcnt_d;
    logic [FLIT_SIZE-1:0] bcnt_q, bcnt_d;
    logic [FLIT_SIZE-1:0] text_q, text_d;
    logic [FLIT_SIZE-1:0] bin_words_q, bin_words_d;

    logic [FLIT_SIZE:0]   task_inc;
    logic [FLIT_SIZE:0]   gcnt_inc;
    logic [FLIT_SIZE:0]   bcnt_inc;
    logic [FLIT_SIZE:0]   bin_sum;
    logic                 more_tasks;
    logic                 advance_task;
    logic                 tag_err;
    logic                 ovf_err;

    logic                 err_q;
    logic                 done_q;
    logic                 accept;
    logic                 pop;
    logic [CNT_W-1:0]     fifo_count;
    logic [3:0]           cur_field;
    logic [TASK_IDX_W-1:0] cur_task;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head_entry;

    assign credit_o    = (fifo_count < CNT_W'(BUF_DEPTH)) && !done_q;
    assign accept      = tx_i && credit_o;
    assign out_valid_o = (fifo_count != '0);
    assign pop         = out_valid_o && out_ready_i;

    assign busy_o = (state_q != S_DSIZE);
    assign done_o = done_q;
    assign err_o  = err_q;

    // Counter increments are one bit wider so the compares never wrap.
    assign task_inc   = {1'b0, task_q} + (FLIT_SIZE + 1)'(1);
    assign gcnt_inc   = {1'b0, gcnt_q} + (FLIT_SIZE + 1)'(1);
    assign bcnt_inc   = {1'b0, bcnt_q} + (FLIT_SIZE + 1)'(1);
    assign bin_sum    = {1'b0, text_q} + {1'b0, data_i};
    assign more_tasks = (task_inc < {1'b0, tcnt_q});

    // Each flit is tagged with the field of the state that consumes it.
    assign cur_field  = 4'(state_q);
    assign cur_task   = field_has_task(app_field_e'(state_q)) ? task_q[TASK_IDX_W-1:0]
                                                              : '0;
    assign push_entry = {cur_field, cur_task, data_i};

    app_flit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (accept),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .data_o      (head_entry)
    );

    assign {out_field_o, out_task_o, out_data_o} = head_entry;

    // Record parser: next state and counter updates on accepted flits.
    always_comb begin
        state_d      = state_q;
        dsize_d      = dsize_q;
        tcnt_d       = tcnt_q;
        task_d       = task_q;
        gcnt_d       = gcnt_q;
        bcnt_d       = bcnt_q;
        text_d       = text_q;
        bin_words_d  = bin_words_q;
        advance_task = 1'b0;
        tag_err      = 1'b0;
        ovf_err      = 1'b0;

        if (accept) begin
            unique case (state_q)
                S_DSIZE: begin
                    dsize_d = data_i;
                    state_d = S_TCNT;
                end
                S_TCNT: begin
                    tcnt_d  = data_i;
                    task_d  = '0;
                    ovf_err = ({1'b0, data_i} > TASK_LIMIT);
                    if (data_i != '0) begin
                        state_d = S_MAP;
                    end else if (dsize_q != '0) begin
                        state_d = S_GRAPH;
                    end else begin
                        state_d = S_DSIZE;
                    end
                end
                S_MAP: begin
                    state_d = S_TAG;
                end
                S_TAG: begin
                    tag_err = (data_i != FLIT_SIZE'(TASK_TAG));
                    if (more_tasks) begin
                        task_d  = task_inc[FLIT_SIZE-1:0];
                        state_d = S_MAP;
                    end else begin
                        task_d  = '0;
                        state_d = (dsize_q != '0) ? S_GRAPH : S_TEXT;
                    end
                end
                S_GRAPH: begin
                    if (gcnt_inc == {1'b0, dsize_q}) begin
                        gcnt_d  = '0;
                        state_d = (tcnt_q != '0) ? S_TEXT : S_DSIZE;
                    end else begin
                        gcnt_d = gcnt_inc[FLIT_SIZE-1:0];
                    end
                end
                S_TEXT: begin
                    text_d  = data_i;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    bin_words_d = FLIT_SIZE'(bin_sum >> 2);
                    state_d     = S_BSS;
                end
                S_BSS: begin
                    state_d = S_ENTRY;
                end
                S_ENTRY: begin
                    if (bin_words_q != '0) begin
                        state_d = S_BIN;
                    end else begin
                        advance_task = 1'b1;
                    end
                end
                S_BIN: begin
                    if (bcnt_inc == {1'b0, bin_words_q}) begin
                        bcnt_d       = '0;
                        advance_task = 1'b1;
                    end else begin
                        bcnt_d = bcnt_inc[FLIT_SIZE-1:0];
                    end
                end
                default: begin
                    state_d = S_DSIZE;
                end
            endcase
        end

        // End of one task's image: move to the next task or close the record.
        if (advance_task) begin
            if (more_tasks) begin
                task_d  = task_inc[FLIT_SIZE-1:0];
                state_d = S_TEXT;
            end else begin
                task_d  = '0;
                state_d = S_DSIZE;
            end
        end
    end

    // Parser state, counters and sticky status flags.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q     <= S_DSIZE;
            dsize_q     <= '0;
            tcnt_q      <= '0;
            task_q      <= '0;
            gcnt_q      <= '0;
            bcnt_q      <= '0;
            text_q      <= '0;
            bin_words_q <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dsize_q     <= dsize_d;
            tcnt_q      <= tcnt_d;
            task_q      <= task_d;
            gcnt_q      <= gcnt_d;
            bcnt_q      <= bcnt_d;
            text_q      <= text_d;
            bin_words_q <= bin_words_d;
            // Bad tag, task index overflow, truncated record, or traffic
            // after the sender declared the stream finished.
            if (tag_err || ovf_err || (eoa_i && (state_q != S_DSIZE)) || (tx_i && done_q)) begin
                err_q <= 1'b1;
            end
            if (eoa_i && (state_q == S_DSIZE) && (fifo_count == '0)) begin
                done_q <= 1'b1;
            end
        end
    end

endmodule

// File: doc/app_stream_receiver.md
Name: app_stream_receiver

Overview:
Synthesizable receiving end of the application injection stream (tx/credit/data flit interface) driven by the simulation-side application parser.
Parses each application record in this order:
- descriptor size
- task count
- mapping/tag pairs
- graph descriptor words
- per-task text/data/BSS/entry headers
- binary words

Every accepted flit is tagged with its field type and task index, buffered, and presented to the task injector's memory-write logic over a valid/ready port. Sits between the external injection link and the injector core.

Parameters:
FLIT_SIZE, 32, flit/data width in bits
BUF_DEPTH, 4, output FIFO depth (power of 2, >=2)
TASK_IDX_W, 8, width of task index counter/output

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset, asynchronous, active-high
tx_i  input  1  sender has a valid flit on data_i
data_i  input  FLIT_SIZE  flit payload
credit_o  output  1  receiver can accept a flit this cycle
eoa_i  input  1  sender finished all applications
out_valid_o  output  1  buffered flit available
out_ready_i  input  1  consumer takes flit
out_field_o  output  4  field tag (app_field_e)
out_task_o  output  TASK_IDX_W  task index for MAP/TAG/TEXT..BIN fields, else 0
out_data_o  output  FLIT_SIZE  flit payload
busy_o  output  1  parser is mid-record (state != S_DSIZE)
done_o  output  1  eoa_i seen while idle and FIFO empty (sticky)
err_o  output  1  sticky protocol error

Behaviour:
- Accept: a flit transfers on a rising clk_i edge when tx_i && credit_o.
- Credit: credit_o = (fifo_count < BUF_DEPTH), taken from the registered count only.
  - A pop does not raise credit in the same cycle.
  - When full with a simultaneous pop, credit_o stays low that cycle.
- Latency: an accepted flit is visible on out_* the next cycle (registered FIFO).
  - Pop on out_valid_o && out_ready_i.
  - When the FIFO is empty, out_data_o/out_field_o hold their last values.
- Reset values (rst_ni asserted, async): all outputs 0 except credit_o=1; state=S_DSIZE; all counters 0; FIFO empty; err_o=0; done_o=0.
- State machine (advances only on accepted flits; each flit is pushed with the field tag of the current state):
  - S_DSIZE: latch dsize (FLIT_SIZE) -> S_TCNT.
  - S_TCNT: latch tcnt.
    - tcnt>0 -> S_MAP, task=0.
    - tcnt==0 -> (dsize>0 ? S_GRAPH : S_DSIZE).
  - S_MAP -> S_TAG.
  - S_TAG: if data != 1, set err_o and still consume.
    - task+1 < tcnt -> S_MAP, task++.
    - else task=0 -> (dsize>0 ? S_GRAPH : S_TEXT).
  - S_GRAPH: gcnt++ each flit; when gcnt+1 == dsize -> S_TEXT (tcnt>0) else S_DSIZE. gcnt cleared on exit.
  - S_TEXT: latch text -> S_DATA.
  - S_DATA: bin_words = (text + data) >> 2 (sum in FLIT_SIZE+1 bits, truncating) -> S_BSS.
  - S_BSS -> S_ENTRY.
  - S_ENTRY: bin_words>0 -> S_BIN, else next task.
  - S_BIN: bcnt++; at bcnt+1 == bin_words -> next task.
  - Next task: task+1 < tcnt -> S_TEXT, task++; else S_DSIZE, task=0.
- out_task_o carries the task index latched with the flit. It is 0 for DSIZE/TCNT/GRAPH.
- Task index overflow: tcnt > 2**TASK_IDX_W sets err_o at S_TCNT; parsing continues and the index wraps.
- eoa_i:
  - If asserted while state != S_DSIZE, set err_o (truncated record).
  - done_o is set when eoa_i && state==S_DSIZE && FIFO empty, and is sticky until reset.
  - After done_o, further tx_i flits set err_o and are not accepted; credit_o is forced 0.
- tx_i without credit: the flit is not accepted; no state change.
- Reset mid-record: everything returns to reset values immediately. A partially received application is discarded.

Decomposition:
- Package app_stream_pkg:
  - typedef enum logic[3:0] app_field_e {F_DSIZE, F_TCNT, F_MAP, F_TAG, F_GRAPH, F_TEXT, F_DATA, F_BSS, F_ENTRY, F_BIN}.
  - The parser state enum reuses the same encodings.
  - Constant TASK_TAG = 1.
- Sub-module: app_flit_fifo.
  - Parameters: width and depth.
  - Ports: push/pop, count, registered output.
  - Width = FLIT_SIZE + 4 + TASK_IDX_W.
- The top holds the FSM and counters.

Test Plan:
1. Basic app, out_ready_i=1:
   - Stream dsize=2, tcnt=1, map=0x11, tag=1, graph 0xA,0xB, text=8, data=4, bss=16, entry=0x100, then 3 binary words.
   - Required: 13 flits out in order with fields DSIZE,TCNT,MAP,TAG,GRAPH×2,TEXT,DATA,BSS,ENTRY,BIN×3; task=0 throughout; busy_o low after the last BIN; err_o=0.
2. Backpressure:
   - Same stream with out_ready_i=0.
   - Required: credit_o drops after exactly 4 accepts. Raising out_ready_i for 1 cycle re-raises credit the following cycle; no flit is lost or duplicated.
3. Two tasks, second with text=0, data=0:
   - Required: the second task goes ENTRY -> S_DSIZE with no BIN flits; out_task_o=1 on its TEXT..ENTRY flits.
4. Bad tag and tcnt=0:
   - Tag flit=2 -> err_o=1, parsing continues.
   - A separate record with dsize=0, tcnt=0 -> returns to S_DSIZE after 2 flits.
5. eoa_i:
   - Asserted idle with FIFO empty -> done_o=1, credit_o=0.
   - Asserted mid-GRAPH -> err_o=1, done_o=0.
6. Async reset pulse mid-BIN:
   - Required: outputs at reset values immediately (credit_o=1, out_valid_o=0). A new record then parses correctly from DSIZE.
